// File: rtl/muxn_rr_registered_if.sv
// Handshake bundle between N producers, the registered mux and its single consumer.
// The mux uses the slave view; the producer/consumer side uses the master view.
interface muxn_rr_registered_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4
);
   localparam int SELW = $clog2(N);

   logic [SELW-1:0]    sel;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_chan;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/muxn_rr_registered.sv
// N-channel valid/ready mux with a single output register stage. The channel comes
// from an external select (MODE 0) or from a round-robin arbiter (MODE 1).
module muxn_rr_registered #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int MODE  = 0
) (
   input logic                 clk,
   input logic                 rst,
   muxn_rr_registered_if.slave bus
);
   localparam int SELW = $clog2(N);

   genvar gi;
   genvar gj;

   logic [WIDTH-1:0] chan_data [N];
   logic [WIDTH-1:0] out_data_reg, out_data_next;
   logic [SELW-1:0]  out_chan_reg, out_chan_next;
   logic             out_valid_reg, out_valid_next;
   logic             load_en;
   logic             gnt_v;
   logic             xfer;
   logic [SELW-1:0]  gnt;
   logic [N-1:0]     in_ready_int;

   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // The register can take a word when empty or when its word leaves this cycle.
   assign load_en = !out_valid_reg || bus.out_ready;
   assign xfer    = rst && load_en && gnt_v;

   generate
      if (MODE == 0) begin : g_sel
         // Only in-range select values can match a channel, so sel >= N never grants.
         logic [N-1:0] sel_hit;

         for (gi = 0; gi < N; gi++) begin : g_hit
            assign sel_hit[gi] = (bus.sel == SELW'(gi));
         end

         assign gnt   = bus.sel;
         assign gnt_v = |(sel_hit & bus.in_valid);
      end else begin : g_rr
         localparam logic [SELW+1:0] N_EXT = (SELW+2)'(N);

         logic [SELW-1:0]         ptr_reg, ptr_next;
         logic [SELW+1:0]         rot_amt;
         logic [SELW+1:0]         gnt_sum;
         logic [2*N-1:0]          valid_dbl;
         logic [N-1:0]            valid_rot;
         logic [N-1:0]            lower_any;
         logic [N-1:0]            first_hit;
         logic [SELW-1:0][N-1:0]  off_bits;
         logic [SELW-1:0]         rr_off;

         // Bit j of valid_rot is channel (ptr+1+j) mod N, so the lowest set bit is the winner.
         assign rot_amt   = {2'b00, ptr_reg} + (SELW+2)'(1);
         assign valid_dbl = {bus.in_valid, bus.in_valid};
         assign valid_rot = N'(valid_dbl >> rot_amt);

         for (gi = 0; gi < N; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
               assign lower_any[gi] = 1'b0;
            end else begin : g_upper
               assign lower_any[gi] = |valid_rot[gi-1:0];
            end
            assign first_hit[gi] = valid_rot[gi] && !lower_any[gi];
         end

         // Encode the one-hot winner: each offset bit ORs the winners whose index has that bit set.
         for (gj = 0; gj < SELW; gj++) begin : g_enc
            for (gi = 0; gi < N; gi++) begin : g_term
               if (((gi >> gj) & 1) == 1) begin : g_on
                  assign off_bits[gj][gi] = first_hit[gi];
               end else begin : g_off
                  assign off_bits[gj][gi] = 1'b0;
               end
            end
            assign rr_off[gj] = |off_bits[gj];
         end

         assign gnt_sum  = rot_amt + {2'b00, rr_off};
         assign gnt      = (gnt_sum >= N_EXT) ? SELW'(gnt_sum - N_EXT) : SELW'(gnt_sum);
         assign gnt_v    = |bus.in_valid;
         assign ptr_next = xfer ? gnt : ptr_reg;

         // Pointer resets to the last channel so channel 0 is scanned first.
         always_ff @(posedge clk) begin
            if (!rst) begin
               ptr_reg <= SELW'(N - 1);
            end else begin
               ptr_reg <= ptr_next;
            end
         end
      end
   endgenerate

   generate
      for (gi = 0; gi < N; gi++) begin : g_ready
         assign in_ready_int[gi] = xfer && (gnt == SELW'(gi));
      end
   endgenerate

   always_comb begin
      out_data_next  = out_data_reg;
      out_chan_next  = out_chan_reg;
      out_valid_next = out_valid_reg;
      if (load_en) begin
         out_valid_next = xfer;
         if (xfer) begin
            out_data_next = chan_data[gnt];
            out_chan_next = gnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_data_reg  <= '0;
         out_chan_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         out_data_reg  <= out_data_next;
         out_chan_reg  <= out_chan_next;
         out_valid_reg <= out_valid_next;
      end
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.out_data  = out_data_reg;
   assign bus.out_chan  = out_chan_reg;
   assign bus.out_valid = out_valid_reg;
endmodule
